local_mem_avmm_rd_credit: RTL

- Sits between the AFU-side local-memory Avalon-MM master (one per bank) and the per-bank DDR4 AVMM pipeline bridge, in the bank's USERCLK domain.
- Gives the AFU read-response backpressure (s0_readready), which plain Avalon-MM and DDR4 cannot provide.
- Does this by buffering read beats in a response FIFO and admitting a read burst only when enough FIFO space is reserved.
- Also enforces whole write bursts: reads are never issued mid write burst.

---
 rtl/local_mem_avmm_pkg.sv | 17 +
 rtl/local_mem_avmm_rsp_fifo.sv | 60 ++++++
 rtl/local_mem_avmm_rd_credit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/local_mem_avmm_pkg.sv
// Shared types and helpers for the local-memory AVMM read-credit shim.
// Write-burst tracking states and burstcount normalisation live here.
package local_mem_avmm_pkg;

    localparam int BYTEENABLE_WIDTH = 512 / 8;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } t_wr_state;

    // A zero burstcount is illegal on the bus; treat it as a single beat.
    function automatic int unsigned burst_beats(input int unsigned bc);
        return (bc == 0) ? 32'd1 : bc;
    endfunction

endpackage

// File: rtl/local_mem_avmm_rsp_fifo.sv
// Show-ahead response FIFO: a beat pushed in cycle N is at the head in cycle N+1.
// No backpressure on push; a push into a full FIFO without a pop is dropped.
module local_mem_avmm_rsp_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Registered read at the next head address; bypass when that slot is being written now.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
        if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            head_q <= push_dat_i;
        end else begin
            head_q <= mem[rd_ptr_d[AW-1:0]];
        end
    end

    assign head_dat_o = head_q;

endmodule

// File: rtl/local_mem_avmm_rd_credit.sv
// AVMM shim adding read-response backpressure: reads issue only with reserved FIFO credits, zero-latency command path.
// Responses land in a show-ahead FIFO (N+1); reads stall mid write burst or when credits are short.
module local_mem_avmm_rd_credit
    import local_mem_avmm_pkg::*;
#(
    parameter int DATA_WIDTH       = 512,
    parameter int SYMBOL_WIDTH     = 8,
    parameter int ADDR_WIDTH       = 27,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int MAX_RD_BEATS     = 128
) (
    input  logic                                  clk,
    input  logic                                  reset,
    output logic                                  s0_waitrequest,
    output logic [DATA_WIDTH-1:0]                 s0_readdata,
    output logic                                  s0_readdatavalid,
    input  logic                                  s0_readready,
    input  logic [BURSTCOUNT_WIDTH-1:0]           s0_burstcount,
    input  logic [DATA_WIDTH-1:0]                 s0_writedata,
    input  logic [ADDR_WIDTH-1:0]                 s0_address,
    input  logic                                  s0_write,
    input  logic                                  s0_read,
    input  logic [DATA_WIDTH/SYMBOL_WIDTH-1:0]    s0_byteenable,
    input  logic                                  m0_waitrequest,
    input  logic [DATA_WIDTH-1:0]                 m0_readdata,
    input  logic                                  m0_readdatavalid,
    output logic [BURSTCOUNT_WIDTH-1:0]           m0_burstcount,
    output logic [DATA_WIDTH-1:0]                 m0_writedata,
    output logic [ADDR_WIDTH-1:0]                 m0_address,
    output logic                                  m0_write,
    output logic                                  m0_read,
    output logic [DATA_WIDTH/SYMBOL_WIDTH-1:0]    m0_byteenable,
    output logic [$clog2(MAX_RD_BEATS+1)-1:0]     rd_credits,
    output logic                                  rd_overflow_err
);

    localparam int CW    = $clog2(MAX_RD_BEATS + 1);
    localparam int CNT_W = $clog2(MAX_RD_BEATS) + 1;

    if ((MAX_RD_BEATS < (1 << (BURSTCOUNT_WIDTH - 1))) ||
        ((MAX_RD_BEATS & (MAX_RD_BEATS - 1)) != 0)) begin : g_bad_cfg
        $error("MAX_RD_BEATS must be a power of 2 and >= 2**(BURSTCOUNT_WIDTH-1)");
    end

    t_wr_state                   state_q, state_d;
    logic [BURSTCOUNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0]               credits_q, credits_d;
    logic                        err_q, err_d;

    logic [CW-1:0]               beats;
    logic                        rd_ok, rd_acc, wr_acc, pop;
    logic                        fifo_full, fifo_empty;
    logic [CNT_W-1:0]            fifo_count;

    assign beats  = CW'(burst_beats(32'(s0_burstcount)));
    assign rd_ok  = s0_read && (state_q == W_IDLE) && (credits_q >= beats);
    assign rd_acc = rd_ok && !m0_waitrequest;
    assign wr_acc = s0_write && !m0_waitrequest;
    assign pop    = s0_readdatavalid && s0_readready;

    assign m0_read        = rd_ok;
    assign m0_write       = s0_write;
    assign m0_burstcount  = s0_burstcount;
    assign m0_writedata   = s0_writedata;
    assign m0_address     = s0_address;
    assign m0_byteenable  = s0_byteenable;
    assign s0_waitrequest = m0_waitrequest || (s0_read && !rd_ok);

    assign s0_readdatavalid = !fifo_empty;
    assign rd_credits       = credits_q;
    assign rd_overflow_err  = err_q;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        credits_d = credits_q - (rd_acc ? beats : CW'(0)) + CW'(pop);
        err_d     = err_q | (m0_readdatavalid && fifo_full && !pop);
        case (state_q)
            W_IDLE: begin
                // Only the first beat's burstcount matters; later beats' value is ignored.
                if (wr_acc && (beats > CW'(1))) begin
                    state_d = W_BURST;
                    wcnt_d  = BURSTCOUNT_WIDTH'(beats - CW'(1));
                end
            end
            W_BURST: begin
                if (wr_acc) begin
                    wcnt_d = wcnt_q - BURSTCOUNT_WIDTH'(1);
                    if (wcnt_q == BURSTCOUNT_WIDTH'(1)) begin
                        state_d = W_IDLE;
                    end
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= W_IDLE;
            wcnt_q    <= '0;
            credits_q <= CW'(MAX_RD_BEATS);
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    local_mem_avmm_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MAX_RD_BEATS)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (reset),
        .push_i     (m0_readdatavalid),
        .push_dat_i (m0_readdata),
        .pop_i      (pop),
        .head_dat_o (s0_readdata),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    a_bc_nonzero: assert property (@(posedge clk) disable iff (reset)
        (s0_read || (s0_write && state_q == W_IDLE)) |-> (s0_burstcount != '0));

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        fifo_count <= CNT_W'(MAX_RD_BEATS));

endmodule
